// File: rtl/adder_pkg.sv
// Shared constants and state encoding for the bit-serial adder.
package adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Controller states; values fixed so they match the other datapath blocks.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// Combinational 1-bit full-adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Sum and majority carry.
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock, start/done handshake.
module serial_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] psum;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_s;
  logic             fa_c;
  logic             last_bit;
  logic             accept;

  // Single shared adder cell working on the operand LSBs.
  full_adder u_fa (
    .a   (ra[0]),
    .b   (rb[0]),
    .cin (carry),
    .s   (fa_s),
    .cout(fa_c)
  );

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  assign accept   = start && ((state == IDLE) || (state == DONE));

  // Status flags decode straight off the state register.
  assign busy = (state == RUN);
  assign done = (state == DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; start is ignored while RUN is in progress.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand shifters, carry, bit counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ra    <= '0;
      rb    <= '0;
      psum  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      ra    <= a;
      rb    <= b;
      psum  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (state == RUN) begin
      ra    <= {1'b0, ra[WIDTH-1:1]};
      rb    <= {1'b0, rb[WIDTH-1:1]};
      psum  <= {fa_s, psum[WIDTH-1:1]};
      carry <= fa_c;
      if (last_bit) begin
        // Publish the full result only at completion so partial sums never leak.
        sum  <= {fa_s, psum[WIDTH-1:1]};
        cout <= fa_c;
        ovf  <= carry ^ fa_c;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at WIDTH=8.
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;
  logic         done;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] last_sum;
  logic         last_cout;
  logic         last_ovf;

  serial_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf),
    .busy (busy),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: pass a rising edge and land on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One operation: mode 0 plain, 1 extra start pulse mid-RUN, 2 operands scrambled during RUN.
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] es, input logic ec, input logic ev,
                       input int mode, input string tag);
    start = 1'b1;
    a     = av;
    b     = bv;
    tick();
    start = 1'b0;
    for (int i = 1; i <= int'(W); i++) begin
      chk({tag, " run busy/done"}, 32'({busy, done}), 32'(2'b10));
      chk({tag, " sum hold"}, 32'(sum), 32'(last_sum));
      start = 1'b0;
      if (mode == 1 && i == 4) begin
        start = 1'b1;
        a     = 8'hAA;
        b     = 8'h55;
      end
      if (mode == 2) begin
        a = W'($urandom);
        b = W'($urandom);
      end
      tick();
    end
    start = 1'b0;
    a     = '0;
    b     = '0;
    chk({tag, " done busy/done"}, 32'({busy, done}), 32'(2'b01));
    chk({tag, " sum"}, 32'(sum), 32'(es));
    chk({tag, " cout"}, 32'(cout), 32'(ec));
    chk({tag, " ovf"}, 32'(ovf), 32'(ev));
    last_sum  = es;
    last_cout = ec;
    last_ovf  = ev;
    tick();
    chk({tag, " after busy/done"}, 32'({busy, done}), 32'(2'b00));
  endtask

  int done_gap;
  int done_seen;

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    a         = '0;
    b         = '0;
    last_sum  = '0;
    last_cout = 1'b0;
    last_ovf  = 1'b0;
    @(negedge clk);
    tick();
    tick();

    // Reset state.
    chk("reset busy/done", 32'({busy, done}), 32'(2'b00));
    chk("reset sum", 32'(sum), 32'(0));
    chk("reset cout/ovf", 32'({cout, ovf}), 32'(2'b00));

    // rst and start together: reset wins.
    start = 1'b1;
    a     = 8'h12;
    b     = 8'h34;
    tick();
    chk("rst+start busy", 32'(busy), 32'(0));
    rst   = 1'b0;
    start = 1'b0;
    tick();
    chk("idle no start busy", 32'(busy), 32'(0));

    // Basic and carry/overflow corners.
    do_op(8'h3C, 8'h42, 8'h7E, 1'b0, 1'b0, 0, "basic");
    do_op(8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 0, "ff+01");
    do_op(8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 0, "7f+01");
    do_op(8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 0, "80+80");

    // Start during RUN is ignored.
    do_op(8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 1, "start_in_run");
    for (int i = 0; i < 4; i++) begin
      chk("no second op busy/done", 32'({busy, done}), 32'(2'b00));
      tick();
    end

    // Operand stability during RUN.
    do_op(8'h11, 8'h22, 8'h33, 1'b0, 1'b0, 2, "stable");

    // Back-to-back with start held high.
    start = 1'b1;
    a     = 8'h01;
    b     = 8'h01;
    tick();
    done_seen = 0;
    done_gap  = 0;
    for (int i = 1; i <= 20 && done_seen < 2; i++) begin
      tick();
      if (done_seen == 1) done_gap++;
      if (done_seen == 1 && done == 1'b0) begin
        chk("b2b sum hold", 32'(sum), 32'(8'h02));
      end
      if (done) begin
        done_seen++;
        if (done_seen == 1) begin
          chk("b2b first latency", 32'(i), 32'(W));
          chk("b2b first sum", 32'(sum), 32'(8'h02));
          a = 8'h05;
          b = 8'h03;
        end else begin
          chk("b2b gap", 32'(done_gap), 32'(9));
          chk("b2b second sum", 32'(sum), 32'(8'h08));
          start = 1'b0;
        end
      end
    end
    chk("b2b done count", 32'(done_seen), 32'(2));
    start = 1'b0;
    a     = '0;
    b     = '0;
    tick();
    chk("b2b idle", 32'({busy, done}), 32'(2'b00));
    last_sum  = 8'h08;
    last_cout = 1'b0;
    last_ovf  = 1'b0;

    // Reset mid-operation after a completed add.
    do_op(8'h3C, 8'h42, 8'h7E, 1'b0, 1'b0, 0, "pre_reset");
    start = 1'b1;
    a     = 8'hF0;
    b     = 8'h0F;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("mid run busy", 32'(busy), 32'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort busy/done", 32'({busy, done}), 32'(2'b00));
    chk("abort sum", 32'(sum), 32'(0));
    chk("abort cout/ovf", 32'({cout, ovf}), 32'(2'b00));
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done || busy) done_seen++;
    end
    chk("abort no done", 32'(done_seen), 32'(0));
    last_sum  = '0;
    last_cout = 1'b0;
    last_ovf  = 1'b0;
    do_op(8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 0, "fresh");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder, LSB first, one bit per clock. It is the addition counterpart of the team's subtractor datapath blocks.
- Trades latency for area: one full-adder cell, a carry flip-flop and operand shift registers.
- Sits behind a simple start/done handshake so a controller FSM can issue one add per operation.

Parameters:
- WIDTH, 8: operand and sum width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- a  input  WIDTH  operand A; captured on the accepted start edge
- b  input  WIDTH  operand B; captured on the accepted start edge
- sum  output  WIDTH  registered result of a+b mod 2^WIDTH
- cout  output  1  registered unsigned carry out of the MSB
- ovf  output  1  registered signed overflow (carry into MSB XOR carry out)
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; result valid

Behaviour:
- Reset and clock: one clock domain, clk. Reset is synchronous and active-high on rst. Reset values: state=IDLE, sum=0, cout=0, ovf=0, busy=0, done=0, internal shift registers, carry and counter all 0.
- FSM states: IDLE, RUN, DONE. The state is registered. busy=(state==RUN) and done=(state==DONE) are decoded directly from the state register.
- IDLE:
  - start=1 at edge E loads ra<=a and rb<=b, clears carry, clears the bit counter, and moves to RUN.
  - start=0 stays in IDLE.
- RUN, on each edge:
  - s = ra[0]^rb[0]^c.
  - c <= majority(ra[0], rb[0], c).
  - ra and rb shift right by 1, MSB filled with 0.
  - The partial-sum register shifts right with s inserted at bit WIDTH-1.
  - The counter increments.
- RUN exit, on the edge where the counter equals WIDTH-1 (the WIDTH-th RUN edge):
  - sum <= final partial sum including this bit.
  - cout <= carry out of this bit.
  - ovf <= carry-in of this bit XOR its carry out.
  - Move to DONE.
- Latency: start is sampled at edge E. done is high for exactly one cycle, between edge E+WIDTH and edge E+WIDTH+1.
- DONE, on the next edge:
  - start=1 gives a back-to-back accept: operands load exactly as in IDLE and the FSM goes to RUN.
  - Otherwise the FSM returns to IDLE.
- start while in RUN is ignored. The operation in flight is not disturbed and no request is queued.
- a and b are don't-care outside the accepting edge. Changing them during RUN has no effect.
- sum, cout and ovf hold their last completed result until the next completion. They never show partial values.
- rst asserted mid-RUN:
  - Abort at the next edge and force the reset values, including clearing sum/cout/ovf.
  - No done pulse is issued for the aborted operation.
- rst and start high on the same edge: rst wins and state=IDLE.
- Width rules:
  - The counter is $clog2(WIDTH) bits and never wraps past WIDTH-1.
  - There is no internal sign extension; the result is modulo 2^WIDTH.

Decomposition:
- Shared package or include (adder_pkg): state encoding localparams IDLE=2'd0, RUN=2'd1, DONE=2'd2, plus the default WIDTH constant.
- Sub-module full_adder: combinational 1-bit cell with inputs a, b, cin and outputs s, cout. It is instantiated once in serial_adder.
- The FSM, counter and shift registers stay in serial_adder.

Test Plan (WIDTH=8):
- Basic add: a=8'h3C, b=8'h42, start pulsed for 1 cycle -> done high exactly 8 cycles after the start edge for 1 cycle; sum=8'h7E, cout=0, ovf=0; busy high for 8 cycles.
- Carry and overflow corners:
  - 8'hFF+8'h01 -> sum=8'h00, cout=1, ovf=0.
  - 8'h7F+8'h01 -> sum=8'h80, cout=0, ovf=1.
  - 8'h80+8'h80 -> sum=8'h00, cout=1, ovf=1.
- Start during RUN: a=8'h10, b=8'h20 started; pulse start with a=8'hAA, b=8'h55 at RUN cycle 3 -> single done, sum=8'h30; no second operation.
- Back-to-back: hold start=1 continuously with a=8'h01, b=8'h01, then a=8'h05, b=8'h03 presented at the DONE cycle -> done pulses 9 cycles apart; sum=8'h02 then 8'h08; sum holds 8'h02 between them.
- Reset mid-operation: after a completed 8'h3C+8'h42, start 8'hF0+8'h0F and assert rst at RUN cycle 4 -> next cycle state IDLE, busy=0, sum=0, cout=0, ovf=0, no done pulse. A fresh 8'h01+8'h02 afterwards gives sum=8'h03.
- Operand stability: change a and b every cycle during RUN of 8'h11+8'h22 -> sum=8'h33 unaffected.
